// File: rtl/div_seq_pkg.sv
// Shared codes for the execute-stage divide sequencer: FSM states,
// handshake levels and the fixed operand width.
package div_seq_pkg;

  localparam int WIDTH = 32;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [WIDTH-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    DIV_FREE   = DivFree,
    DIV_BYZERO = DivByZero,
    DIV_ON     = DivOn,
    DIV_END    = DivEnd
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: trial-subtract the divisor from the top 33
// bits of the work register and shift in the resulting quotient bit.
module div_step
  import div_seq_pkg::*;
(
  input  logic [2*WIDTH:0]   work,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH:0]   work_nxt
);

  logic [WIDTH:0] diff;

  assign diff = work[2*WIDTH:WIDTH] - {1'b0, divisor};

  // diff[WIDTH] is a true sign: the partial remainder is always below 2*divisor
  always_comb begin
    work_nxt = {work[2*WIDTH-1:0], 1'b0};
    if (!diff[WIDTH])
      work_nxt = {diff[WIDTH-1:0], work[WIDTH-1:0], 1'b1};
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer: start/annul/retire handshake with ex,
// 32 restoring iterations, sign fix-up and a held {rem, quot} result.
module div_seq
  import div_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o
);

  div_state_e          state;
  logic [5:0]          cnt;
  logic [2*WIDTH:0]    work, work_nxt;
  logic [WIDTH-1:0]    divisor;
  logic                neg_q, neg_r;
  logic [WIDTH-1:0]    abs1, abs2, q_fix, r_fix;

  assign abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
  assign abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

  div_step u_step (
    .work     (work),
    .divisor  (divisor),
    .work_nxt (work_nxt)
  );

  // Fix-up is applied to the last step's output so the result lands on E32
  assign q_fix = neg_q ? (~work_nxt[WIDTH-1:0] + 1'b1) : work_nxt[WIDTH-1:0];
  assign r_fix = neg_r ? (~work_nxt[2*WIDTH:WIDTH+1] + 1'b1) : work_nxt[2*WIDTH:WIDTH+1];

  assign busy_o = (state != DIV_FREE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      case (state)
        DIV_FREE: begin
          ready_o  <= DivResultNotReady;
          result_o <= '0;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == ZeroWord) begin
              state <= DIV_BYZERO;
            end else begin
              work    <= {ZeroWord, abs1, 1'b0};
              divisor <= abs2;
              neg_q   <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              neg_r   <= signed_div_i && opdata1_i[WIDTH-1];
              cnt     <= '0;
              state   <= DIV_ON;
            end
          end
        end
        DIV_BYZERO: begin
          result_o <= {ZeroWord, ZeroWord};
          ready_o  <= DivResultReady;
          state    <= DIV_END;
        end
        DIV_ON: begin
          if (annul_i) begin
            cnt   <= '0;
            state <= DIV_FREE;
          end else begin
            work <= work_nxt;
            cnt  <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              result_o <= {r_fix, q_fix};
              ready_o  <= DivResultReady;
              state    <= DIV_END;
            end
          end
        end
        DIV_END: begin
          if (start_i == DivStop) begin
            ready_o  <= DivResultNotReady;
            result_o <= '0;
            state    <= DIV_FREE;
          end
        end
        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: scoreboard of expected {rem, quot} values,
// latency, hold, annul, async reset and back-to-back handshakes.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o, busy_o;

  int total = 0;
  int bad   = 0;
  logic [63:0] sbq[$];

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    if (b == 32'd0) return 64'd0;
    ua = (s && a[31]) ? (~a + 32'd1) : a;
    ub = (s && b[31]) ? (~b + 32'd1) : b;
    q  = ua / ub;
    r  = ua % ub;
    if (s && (a[31] ^ b[31])) q = ~q + 32'd1;
    if (s && a[31]) r = ~r + 32'd1;
    return {r, q};
  endfunction

  // Called at a negedge; drives the request, waits for ready, then retires it.
  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat,
                        input int hold);
    int n;
    logic [63:0] e;
    sbq.push_back(exp);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready_o && n < 40);
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    e = sbq.pop_front();
    chk({tag, "_res"}, result_o, e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_res"}, result_o, e);
      chk({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
    end
    start_i = 1'b0;
    @(negedge clk);
    chk({tag, "_rdy_clr"}, 64'(ready_o), 64'd0);
    chk({tag, "_res_clr"}, result_o, 64'd0);
    chk({tag, "_busy_clr"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    start_i = 1'b0; annul_i = 1'b0;
    @(negedge clk);
    chk("rst_res",  result_o, 64'd0);
    chk("rst_rdy",  64'(ready_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 5);
    run_op("div_m7_2",   1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 0);
    run_op("div_7_m2",   1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 0);
    run_op("divu_by0",   1'b0, 32'h12345678, 32'd0, 64'd0, 2, 1);

    // Annul mid-iteration: ready must never rise
    signed_div_i = 1'b0; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd1; start_i = 1'b1;
    repeat (10) @(negedge clk);
    chk("annul_busy_pre", 64'(busy_o), 64'd1);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    chk("annul_busy", 64'(busy_o), 64'd0);
    chk("annul_rdy",  64'(ready_o), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("annul_rdy_stay", 64'(ready_o), 64'd0);
    end
    run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 0);

    // Asynchronous reset around iteration 20
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1;
    repeat (21) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_res",  result_o, 64'd0);
    chk("arst_rdy",  64'(ready_o), 64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 0);

    // Back-to-back with start low for exactly one cycle
    run_op("divu_15_4",    1'b0, 32'd15, 32'd4, 64'h00000003_00000003, 33, 0);
    run_op("divu_1000_10", 1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 33, 0);

    for (int k = 0; k < 6; k++) begin
      rs = k[0];
      ra = $urandom;
      rb = (k == 4) ? 32'd0 : ((k == 5) ? 32'hFFFFFFFF : $urandom_range(1, 32'h0000FFFF));
      if (k == 2) rb = ~rb + 32'd1;
      run_op("rand", rs, ra, rb, model(rs, ra, rb), (rb == 32'd0) ? 2 : 33, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
